alien_shot_scheduler: RTL and testbench

Decides when and from which alien column an enemy shot is fired. It sits directly around the random-number stage. It issues the `rand_req` rising-edge strobe that the random stage latches its fast counter on. It then consumes the latched `rand_val` to pick a starting column and scans for a column with a live alien. Its `fire`/`fire_col` outputs feed the alien-shot object, which reports back through `shot_busy`.

---
 rtl/alien_shot_scheduler.sv | 132 +++++++++++++
 tb/tb_alien_shot_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alien_shot_scheduler.sv
// Alien shot scheduler: frame-paced shot timer, random-start live-column scan, one-cycle fire strobe.
// Latency: rand_req one cycle after the INTERVAL-th frame pulse; fire 3..2+NUM_COLS cycles after rand_req.
// Backpressure: shot_busy or an empty field holds the timer saturated until clear; committed shots are not stalled.
module alien_shot_scheduler #(
    parameter int NUM_COLS  = 8,
    parameter int RAND_BITS = 11,
    parameter int INTERVAL  = 50
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        startOfFrame,
    input  logic [NUM_COLS-1:0]         alive_cols,
    input  logic                        shot_busy,
    input  logic [RAND_BITS-1:0]        rand_val,
    output logic                        rand_req,
    output logic                        fire,
    output logic [$clog2(NUM_COLS)-1:0] fire_col
);

    localparam int               COL_W      = $clog2(NUM_COLS);
    localparam int               SCAN_W     = COL_W + 1;
    localparam logic [SCAN_W-1:0] SCAN_END  = SCAN_W'(NUM_COLS);
    localparam logic [7:0]       INTERVAL_C = 8'(INTERVAL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_REQ,
        S_LATCH,
        S_SEARCH,
        S_FIRE
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [COL_W-1:0]    idx_q, idx_d;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [COL_W-1:0]    fire_col_q, fire_col_d;
    logic                rand_req_q, rand_req_d;
    logic                fire_q, fire_d;

    // Only the low COL_W bits of the random value select a column.
    logic unused_rand;
    assign unused_rand = ^rand_val;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        scan_cnt_d = scan_cnt_q;
        fire_col_d = fire_col_q;

        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                state_d = S_COUNT;
            end
            S_COUNT: begin
                if (startOfFrame && (cnt_q < INTERVAL_C)) begin
                    cnt_d = cnt_q + 8'd1;
                end
                // Decide on the incremented count so REQ follows the last frame pulse directly.
                if ((cnt_d == INTERVAL_C) && !shot_busy && (|alive_cols)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                idx_d      = rand_val[COL_W-1:0];
                scan_cnt_d = '0;
                state_d    = S_SEARCH;
            end
            S_SEARCH: begin
                if (alive_cols[idx_q]) begin
                    fire_col_d = idx_q;
                    state_d    = S_FIRE;
                end else begin
                    idx_d      = idx_q + 1'b1;
                    scan_cnt_d = scan_cnt_q + 1'b1;
                    // Failed sweep: counter stays saturated so the retry needs no new frames.
                    if (scan_cnt_d == SCAN_END) begin
                        state_d = S_COUNT;
                    end
                end
            end
            S_FIRE: begin
                cnt_d   = '0;
                state_d = S_COUNT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!enable) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            fire_col_d = fire_col_q;
        end

        rand_req_d = (state_d == S_REQ);
        fire_d     = (state_d == S_FIRE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            scan_cnt_q <= '0;
            fire_col_q <= '0;
            rand_req_q <= 1'b0;
            fire_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            scan_cnt_q <= scan_cnt_d;
            fire_col_q <= fire_col_d;
            rand_req_q <= rand_req_d;
            fire_q     <= fire_d;
        end
    end

    assign rand_req = rand_req_q;
    assign fire     = fire_q;
    assign fire_col = fire_col_q;

endmodule

// File: tb/tb_alien_shot_scheduler.sv
// Directed bench for alien_shot_scheduler with a latching random-stage model (NUM_COLS=8, INTERVAL=4).
// Latency: checks rand_req at t+1 after the last frame and fire at r+3+k for a hit k columns past start.
// Backpressure: exercises shot_busy hold, empty fields, abort and reset mid-scan.
module tb_alien_shot_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        startOfFrame;
    logic [7:0]  alive_cols;
    logic        shot_busy;
    logic [10:0] rand_val = 11'd0;
    logic [10:0] rand_seed;
    logic        rand_req;
    logic        fire;
    logic [2:0]  fire_col;

    int errors = 0;
    int checks = 0;
    int req_cnt = 0;
    int fire_cnt = 0;
    logic req_prev = 1'b0;
    logic h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
    logic gap_bad = 1'b0;

    always #5 clk = ~clk;

    alien_shot_scheduler #(
        .NUM_COLS (8),
        .RAND_BITS(11),
        .INTERVAL (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .startOfFrame(startOfFrame),
        .alive_cols  (alive_cols),
        .shot_busy   (shot_busy),
        .rand_val    (rand_val),
        .rand_req    (rand_req),
        .fire        (fire),
        .fire_col    (fire_col)
    );

    // Random stage: latches the current seed at the clock edge ending the first rand_req cycle.
    always @(posedge clk) begin
        if (rand_req === 1'b1 && req_prev === 1'b0) rand_val <= rand_seed;
        req_prev <= rand_req;
    end

    always @(negedge clk) begin
        if (rand_req === 1'b1) req_cnt++;
        if (fire === 1'b1) fire_cnt++;
        if (rand_req === 1'b1 && (h1 || h2 || h3)) gap_bad = 1'b1;
        h3 = h2;
        h2 = h1;
        h1 = (rand_req === 1'b1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
    endtask

    task automatic frames_gap(input int n);
        for (int i = 0; i < n; i++) begin
            frame();
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; startOfFrame = 1'b0; shot_busy = 1'b0;
        alive_cols = 8'hFF; rand_seed = 11'd13;
        steps(3);
        checks++; if (rand_req !== 1'b0) begin errors++; $display("FAIL reset_rand_req: got %b want 0", rand_req); end
        checks++; if (fire !== 1'b0) begin errors++; $display("FAIL reset_fire: got %b want 0", fire); end
        checks++; if (fire_col !== 3'd0) begin errors++; $display("FAIL reset_fire_col: got %0d want 0", fire_col); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic_shot();
        int n0;
        rand_seed = 11'd13;
        n0 = req_cnt;
        frames_gap(3);
        checks++; if (req_cnt !== n0) begin errors++; $display("FAIL basic_no_early_req: got %0d reqs want %0d", req_cnt, n0); end
        frame();
        checks++; if (rand_req !== 1'b1) begin errors++; $display("FAIL basic_req_at_t1: got %b want 1", rand_req); end
        step();
        checks++; if (rand_req !== 1'b0) begin errors++; $display("FAIL basic_req_one_cycle: got %b want 0", rand_req); end
        step();
        checks++; if (fire !== 1'b0) begin errors++; $display("FAIL basic_fire_early: got %b want 0", fire); end
        step();
        checks++; if (fire !== 1'b1) begin errors++; $display("FAIL basic_fire_r3: got %b want 1", fire); end
        checks++; if (fire_col !== 3'd5) begin errors++; $display("FAIL basic_fire_col: got %0d want 5", fire_col); end
        step();
        checks++; if (fire !== 1'b0) begin errors++; $display("FAIL basic_fire_one_cycle: got %b want 0", fire); end
    endtask

    task automatic test_shot_spacing();
        int n0;
        n0 = req_cnt;
        frames_gap(3);
        checks++; if (req_cnt !== n0) begin errors++; $display("FAIL spacing_no_req: got %0d reqs want %0d", req_cnt, n0); end
        frame();
        checks++; if (rand_req !== 1'b1) begin errors++; $display("FAIL spacing_req: got %b want 1", rand_req); end
        steps(3);
        checks++; if (fire !== 1'b1) begin errors++; $display("FAIL spacing_fire: got %b want 1", fire); end
        step();
    endtask

    task automatic test_wrap_scan();
        logic early;
        early = 1'b0;
        rand_seed = 11'd6;
        alive_cols = 8'b0000_0010;
        frames_gap(3);
        frame();
        checks++; if (rand_req !== 1'b1) begin errors++; $display("FAIL wrap_req: got %b want 1", rand_req); end
        for (int k = 1; k < 6; k++) begin
            step();
            if (fire === 1'b1) early = 1'b1;
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL wrap_fire_early: got %b want 0", early); end
        step();
        checks++; if (fire !== 1'b1) begin errors++; $display("FAIL wrap_fire_r6: got %b want 1", fire); end
        checks++; if (fire_col !== 3'd1) begin errors++; $display("FAIL wrap_fire_col: got %0d want 1", fire_col); end
        step();
        checks++; if (fire !== 1'b0) begin errors++; $display("FAIL wrap_fire_one_cycle: got %b want 0", fire); end
        checks++; if (fire_col !== 3'd1) begin errors++; $display("FAIL wrap_col_hold: got %0d want 1", fire_col); end
    endtask

    task automatic test_busy_hold();
        int n0;
        alive_cols = 8'hFF;
        rand_seed = 11'd13;
        shot_busy = 1'b1;
        n0 = req_cnt;
        frames_gap(10);
        checks++; if (req_cnt !== n0) begin errors++; $display("FAIL busy_no_req: got %0d reqs want %0d", req_cnt, n0); end
        shot_busy = 1'b0;
        step();
        checks++; if (rand_req !== 1'b1) begin errors++; $display("FAIL busy_release_req: got %b want 1", rand_req); end
        shot_busy = 1'b1;
        steps(3);
        checks++; if (fire !== 1'b1) begin errors++; $display("FAIL busy_ignored_after_commit: got %b want 1", fire); end
        shot_busy = 1'b0;
        step();
    endtask

    task automatic test_empty_columns();
        int n0;
        int nf;
        logic early;
        early = 1'b0;
        rand_seed = 11'd8;
        alive_cols = 8'h00;
        n0 = req_cnt;
        frames_gap(6);
        checks++; if (req_cnt !== n0) begin errors++; $display("FAIL empty_no_req: got %0d reqs want %0d", req_cnt, n0); end
        alive_cols = 8'hFF;
        step();
        checks++; if (rand_req !== 1'b1) begin errors++; $display("FAIL empty_req_on_alive: got %b want 1", rand_req); end
        alive_cols = 8'h00;
        nf = fire_cnt;
        steps(10);
        checks++; if (fire_cnt !== nf) begin errors++; $display("FAIL empty_no_fire: got %0d fires want %0d", fire_cnt, nf); end
        alive_cols = 8'h80;
        step();
        checks++; if (rand_req !== 1'b1) begin errors++; $display("FAIL empty_retry_req: got %b want 1", rand_req); end
        for (int k = 1; k < 10; k++) begin
            step();
            if (fire === 1'b1) early = 1'b1;
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL worst_fire_early: got %b want 0", early); end
        step();
        checks++; if (fire !== 1'b1) begin errors++; $display("FAIL worst_fire_r10: got %b want 1", fire); end
        checks++; if (fire_col !== 3'd7) begin errors++; $display("FAIL worst_fire_col: got %0d want 7", fire_col); end
        step();
    endtask

    task automatic test_abort();
        int n0;
        int nf;
        alive_cols = 8'h80;
        rand_seed = 11'd8;
        frames_gap(3);
        frame();
        checks++; if (rand_req !== 1'b1) begin errors++; $display("FAIL abort_req: got %b want 1", rand_req); end
        steps(4);
        enable = 1'b0;
        nf = fire_cnt;
        step();
        checks++; if (fire !== 1'b0) begin errors++; $display("FAIL abort_fire: got %b want 0", fire); end
        checks++; if (rand_req !== 1'b0) begin errors++; $display("FAIL abort_rand_req: got %b want 0", rand_req); end
        checks++; if (fire_col !== 3'd7) begin errors++; $display("FAIL abort_col_hold: got %0d want 7", fire_col); end
        frames_gap(2);
        steps(8);
        checks++; if (fire_cnt !== nf) begin errors++; $display("FAIL abort_no_fire: got %0d fires want %0d", fire_cnt, nf); end
        enable = 1'b1;
        alive_cols = 8'hFF;
        rand_seed = 11'd13;
        step();
        n0 = req_cnt;
        frames_gap(3);
        checks++; if (req_cnt !== n0) begin errors++; $display("FAIL abort_counter_cleared: got %0d reqs want %0d", req_cnt, n0); end
        frame();
        checks++; if (rand_req !== 1'b1) begin errors++; $display("FAIL abort_resume_req: got %b want 1", rand_req); end
        steps(3);
        checks++; if (fire !== 1'b1) begin errors++; $display("FAIL abort_resume_fire: got %b want 1", fire); end
        step();
    endtask

    task automatic test_reset_mid_scan();
        int n0;
        int nf;
        alive_cols = 8'h80;
        rand_seed = 11'd8;
        frames_gap(3);
        frame();
        checks++; if (rand_req !== 1'b1) begin errors++; $display("FAIL rst_scan_req: got %b want 1", rand_req); end
        steps(4);
        reset = 1'b1;
        nf = fire_cnt;
        step();
        checks++; if (fire !== 1'b0) begin errors++; $display("FAIL rst_scan_fire: got %b want 0", fire); end
        checks++; if (rand_req !== 1'b0) begin errors++; $display("FAIL rst_scan_rand_req: got %b want 0", rand_req); end
        checks++; if (fire_col !== 3'd0) begin errors++; $display("FAIL rst_scan_fire_col: got %0d want 0", fire_col); end
        reset = 1'b0;
        steps(8);
        checks++; if (fire_cnt !== nf) begin errors++; $display("FAIL rst_scan_no_fire: got %0d fires want %0d", fire_cnt, nf); end
        alive_cols = 8'hFF;
        rand_seed = 11'd13;
        n0 = req_cnt;
        frames_gap(3);
        checks++; if (req_cnt !== n0) begin errors++; $display("FAIL rst_scan_counter_cleared: got %0d reqs want %0d", req_cnt, n0); end
        frame();
        checks++; if (rand_req !== 1'b1) begin errors++; $display("FAIL rst_scan_resume_req: got %b want 1", rand_req); end
        steps(3);
        checks++; if (fire !== 1'b1) begin errors++; $display("FAIL rst_scan_resume_fire: got %b want 1", fire); end
        checks++; if (fire_col !== 3'd5) begin errors++; $display("FAIL rst_scan_resume_col: got %0d want 5", fire_col); end
        step();
    endtask

    task automatic test_req_spacing();
        checks++; if (gap_bad !== 1'b0) begin errors++; $display("FAIL req_gap: got %b want 0", gap_bad); end
    endtask

    initial begin
        test_reset();
        test_basic_shot();
        test_shot_spacing();
        test_wrap_scan();
        test_busy_hold();
        test_empty_columns();
        test_abort();
        test_reset_mid_scan();
        test_req_spacing();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
